// File: rtl/encoder_decoder_stream.sv
// ============================================================================
// Module      : encoder_decoder_stream
// Description : Per-word decode / priority-encode with a 2-entry result FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module encoder_decoder_stream #(
   parameter int K    = 2,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              mode,
   input  logic [2**K-1:0]   w,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [2**K-1:0]   y,
   output logic              zero,
   output logic [CNTW-1:0]   out_cnt
);

   localparam int N = 2**K;

   generate
      if (K < 1 || K > 5) begin : g_k_range_check
         $error("encoder_decoder_stream: K must be in 1..5");
      end
   endgenerate

   logic [1:0]      count_q, count_d;
   logic            wr_ptr_q, wr_ptr_d;
   logic            rd_ptr_q, rd_ptr_d;
   logic            in_ready_q, in_ready_d;
   logic [CNTW-1:0] out_cnt_q, out_cnt_d;
   logic [N:0]      mem_q [2];
   logic [N:0]      mem_d [2];

   logic            push, pop;
   logic [N-1:0]    res_y;
   logic            res_zero;
   logic [K-1:0]    enc_idx;

   // Result of the word currently presented; later set bits overwrite earlier
   // ones, so the highest index wins in encode mode.
   always_comb begin
      res_y    = '0;
      res_zero = 1'b0;
      enc_idx  = '0;
      if (mode) begin
         for (int i = 0; i < N; i++) begin
            if (w[i]) enc_idx = K'(i);
         end
         res_y[K-1:0] = enc_idx;
         res_zero     = (w == '0);
      end else begin
         res_y[w[K-1:0]] = 1'b1;
      end
   end

   assign out_valid = (count_q != 2'd0);
   assign push      = in_valid & in_ready_q;
   assign pop       = out_valid & out_ready;

   always_comb begin
      count_d    = count_q + {1'b0, push} - {1'b0, pop};
      wr_ptr_d   = wr_ptr_q ^ push;
      rd_ptr_d   = rd_ptr_q ^ pop;
      in_ready_d = (count_d < 2'd2);
      out_cnt_d  = out_cnt_q + {{(CNTW-1){1'b0}}, pop};
      mem_d      = mem_q;
      if (push) mem_d[wr_ptr_q] = {res_zero, res_y};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q    <= 2'd0;
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         in_ready_q <= 1'b0;
         out_cnt_q  <= '0;
         mem_q[0]   <= '0;
         mem_q[1]   <= '0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         in_ready_q <= in_ready_d;
         out_cnt_q  <= out_cnt_d;
         mem_q      <= mem_d;
      end
   end

   // Outputs are forced to zero while empty so stale entries never leak.
   assign in_ready = in_ready_q;
   assign y        = out_valid ? mem_q[rd_ptr_q][N-1:0] : '0;
   assign zero     = out_valid ? mem_q[rd_ptr_q][N]     : 1'b0;
   assign out_cnt  = out_cnt_q;

endmodule

`default_nettype wire

// File: doc/encoder_decoder_stream.md
ENCODER_DECODER_STREAM -- requirements
Module: encoder_decoder_stream

Interface
- REQ-001: Parameter K, default 2, sets the binary code width; N = 2**K is the one-hot width, and K SHALL be restricted to 1..5.
- REQ-002: Parameter CNTW, default 16, SHALL set the width of the transaction counter.
- REQ-003: CLK  input  1  the single clock; all state SHALL update on its rising edge.
- REQ-004: RSTN  input  1  reset, asynchronous and active-low.
- REQ-005: IN_VALID  input  1  the upstream word on W/MODE is valid.
- REQ-006: IN_READY  output  1  the block accepts a word this cycle; this output SHALL be registered.
- REQ-007: MODE  input  1  per-word operation: 0 = decode, 1 = priority encode.
- REQ-008: W  input  N  input word; decode mode SHALL use only W[K-1:0].
- REQ-009: OUT_VALID  output  1  Y/ZERO hold a valid result.
- REQ-010: OUT_READY  input  1  downstream accepts the result.
- REQ-011: Y  output  N  result word.
- REQ-012: ZERO  output  1  the priority-encode input was all zeros.
- REQ-013: OUT_CNT  output  CNTW  count of completed output transfers.

Function
- REQ-014: An input transfer SHALL occur on a rising edge where IN_VALID=1 and IN_READY=1; an output transfer SHALL occur on a rising edge where OUT_VALID=1 and OUT_READY=1.
- REQ-015: Decode mode SHALL produce Y = one-hot with bit W[K-1:0] set and ZERO=0; W[N-1:K] SHALL be ignored.
- REQ-016: Priority-encode mode SHALL produce Y[K-1:0] = index of the highest set bit of W and Y[N-1:K] = 0; the highest index SHALL win when multiple bits are set.
- REQ-017: Priority-encode mode with W=0 SHALL produce Y=0 and ZERO=1.
- REQ-018: MODE SHALL be sampled with each word, so consecutive words may use different modes.
- REQ-019: Results SHALL be held in a 2-entry FIFO (entry = Y plus ZERO), and results SHALL leave in acceptance order.
- REQ-020: Latency: a word accepted at edge t while the FIFO is empty SHALL appear on OUT_VALID/Y/ZERO after edge t, i.e. one cycle.
- REQ-021: The occupancy count SHALL be next = count + push - pop, in the range 0..2.
- REQ-022: On simultaneous push and pop, the occupancy SHALL be unchanged and the order SHALL be preserved.
- REQ-023: IN_READY SHALL be registered as (next occupancy < 2).
- REQ-024: No push SHALL ever occur when the FIFO is full, and no word SHALL be lost or duplicated.
- REQ-025: When the FIFO is full and a pop occurs, IN_READY SHALL rise after that same edge.
- REQ-026: OUT_VALID SHALL equal (occupancy != 0).
- REQ-027: Y/ZERO SHALL be stable while OUT_VALID=1 and OUT_READY=0.
- REQ-028: Y/ZERO SHALL be 0 whenever OUT_VALID=0.
- REQ-029: OUT_CNT SHALL increment by 1 on each output transfer and SHALL wrap from 2**CNTW-1 to 0 with no flag.
- REQ-030: IN_VALID=1 while IN_READY=0 SHALL have no effect; the upstream holds the word.

Reset
- REQ-031: While RSTN=0, IN_READY, OUT_VALID, Y, ZERO and OUT_CNT SHALL be 0 and the FIFO SHALL be empty.
- REQ-032: Assertion of RSTN SHALL take effect immediately, without a clock edge, and in-flight words SHALL be discarded.
- REQ-033: IN_READY SHALL go to 1 on the first rising CLK edge with RSTN=1.
- REQ-034: A reset asserted mid-operation, including with the FIFO full, SHALL leave no residual output after release.

Verification
- REQ-035: Decode sweep, K=2, OUT_READY=1, MODE=0, W=0,1,2,3 -> Y=0001,0010,0100,1000, each one cycle after acceptance; OUT_CNT=4.
- REQ-036: Priority encode, K=2, MODE=1: W=0110 -> Y=0010, ZERO=0; W=1011 -> Y=0011; W=0000 -> Y=0000, ZERO=1.
- REQ-037: Backpressure: with OUT_READY=0, stream three words -> IN_READY falls after the 2nd acceptance, Y holds the 1st result; raising OUT_READY then drains all three results in order with no loss.
- REQ-038: Simultaneous push and pop at occupancy 1 for 10 cycles with alternating MODE -> occupancy stays 1, outputs match the per-word mode, OUT_CNT=10.
- REQ-039: Async reset while the FIFO is full, RSTN pulsed low mid-cycle -> outputs 0 immediately; after release IN_READY=1 on the first edge and OUT_VALID=0 until a new word is accepted.
- REQ-040: Counter wrap, CNTW=4: 17 output transfers -> OUT_CNT reads 15, then 0, then 1.
